// File: rtl/rx_level_ctrl_if.sv
// Sample stream in, slicing threshold and status out.
interface rx_level_ctrl_if;
  logic       en;
  logic [7:0] din;
  logic       den;
  logic [7:0] level;
  logic       level_vld;
  logic [7:0] swing;
  logic       no_sig;
  logic       upd;

  // sample source / receiver side
  modport master (
    output en, din, den,
    input  level, level_vld, swing, no_sig, upd
  );

  // threshold controller side
  modport slave (
    input  en, din, den,
    output level, level_vld, swing, no_sig, upd
  );
endinterface

// File: rtl/rx_level_ctrl.sv
// Adaptive slicing threshold: per-window min/max tracking, midpoint level
// with swing qualification, hysteresis and loss-of-signal fallback.
module rx_level_ctrl #(
  parameter int         WIN_LOG     = 4,
  parameter logic [7:0] MIN_SWING   = 8'd32,
  parameter logic [7:0] HYST        = 8'd2,
  parameter logic [7:0] DEF_LEVEL   = 8'd128,
  parameter int         NOSIG_LIMIT = 4
) (
  input logic clk,
  input logic rst_n,              // active-high synchronous reset
  rx_level_ctrl_if.slave bus
);

  localparam int WW = $clog2(NOSIG_LIMIT + 1);
  localparam logic [WW-1:0] WLIM = WW'(NOSIG_LIMIT);

  typedef enum logic [1:0] {IDLE, ACQ, UPDATE} state_t;

  state_t             state_q, state_d;
  logic [WIN_LOG-1:0] cnt_q, cnt_d;
  logic [7:0]         mn_q, mn_d, mx_q, mx_d;
  logic [WW-1:0]      weak_q, weak_d, weak_inc;
  logic [7:0]         level_q, level_d, swing_q, swing_d;
  logic               vld_q, vld_d, nosig_q, nosig_d, upd_q, upd_d;

  logic [7:0] sw, mid, diff;
  logic [8:0] sum;

  // window statistics, used only in UPDATE
  always_comb begin
    sw       = mx_q - mn_q;
    sum      = {1'b0, mx_q} + {1'b0, mn_q};
    mid      = sum[8:1];
    diff     = (mid >= level_q) ? (mid - level_q) : (level_q - mid);
    weak_inc = (weak_q == WLIM) ? weak_q : weak_q + 1'b1;
  end

  // next-state and next-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mn_d    = mn_q;
    mx_d    = mx_q;
    weak_d  = weak_q;
    level_d = level_q;
    swing_d = swing_q;
    vld_d   = vld_q;
    nosig_d = nosig_q;
    upd_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.en) begin
          state_d = ACQ;
          cnt_d   = '0;
          mn_d    = 8'hFF;
          mx_d    = 8'h00;
        end
      end
      ACQ: begin
        if (!bus.en) begin
          state_d = IDLE;           // partial window dropped
        end else if (bus.den) begin
          if (bus.din < mn_q) mn_d = bus.din;
          if (bus.din > mx_q) mx_d = bus.din;
          cnt_d = cnt_q + 1'b1;
          if (&cnt_q) state_d = UPDATE;
        end
      end
      UPDATE: begin
        swing_d = sw;
        if (sw >= MIN_SWING) begin
          nosig_d = 1'b0;
          vld_d   = 1'b1;
          weak_d  = '0;
          if (!vld_q || diff > HYST) begin
            level_d = mid;
            upd_d   = (mid != level_q);
          end
        end else begin
          nosig_d = 1'b1;
          weak_d  = weak_inc;
          if (weak_inc == WLIM) begin
            level_d = DEF_LEVEL;
            vld_d   = 1'b0;
            upd_d   = (level_q != DEF_LEVEL);
          end
        end
        state_d = bus.en ? ACQ : IDLE;
        cnt_d   = '0;
        mn_d    = 8'hFF;
        mx_d    = 8'h00;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mn_q    <= 8'hFF;
      mx_q    <= 8'h00;
      weak_q  <= '0;
      level_q <= DEF_LEVEL;
      swing_q <= 8'h00;
      vld_q   <= 1'b0;
      nosig_q <= 1'b1;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mn_q    <= mn_d;
      mx_q    <= mx_d;
      weak_q  <= weak_d;
      level_q <= level_d;
      swing_q <= swing_d;
      vld_q   <= vld_d;
      nosig_q <= nosig_d;
      upd_q   <= upd_d;
    end
  end

  assign bus.level     = level_q;
  assign bus.level_vld = vld_q;
  assign bus.swing     = swing_q;
  assign bus.no_sig    = nosig_q;
  assign bus.upd       = upd_q;

endmodule

// File: tb/tb_rx_level_ctrl.sv
// Directed bench for rx_level_ctrl: inputs change on negedge, outputs
// are checked on negedge, one cycle after the registering edge.
module tb_rx_level_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  rx_level_ctrl_if bus ();

  rx_level_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // all five outputs at once
  task automatic chk_all(input string tag, input int lvl, input int vld,
                         input int nsig, input int swg, input int up);
    chk({tag, ".level"},     int'(bus.level),     lvl);
    chk({tag, ".level_vld"}, int'(bus.level_vld), vld);
    chk({tag, ".no_sig"},    int'(bus.no_sig),    nsig);
    chk({tag, ".swing"},     int'(bus.swing),     swg);
    chk({tag, ".upd"},       int'(bus.upd),       up);
  endtask

  // n samples alternating a/b; gap=1 puts an idle (den=0, din=0) cycle after each
  task automatic send(input logic [7:0] a, input logic [7:0] b, input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); bus.den = 1'b1; bus.din = (i % 2 == 0) ? a : b;
      if (gap && i != n - 1) begin
        @(negedge clk); bus.den = 1'b0; bus.din = 8'd0;
      end
    end
  endtask

  // UPDATE cycle with chosen den/din, then check outputs and that upd drops
  task automatic finish_win(input string tag, input logic d, input logic [7:0] v,
                            input int lvl, input int vld, input int nsig,
                            input int swg, input int up);
    @(negedge clk); bus.den = d; bus.din = v;
    @(negedge clk); bus.den = 1'b0; bus.din = 8'd0;
    chk_all(tag, lvl, vld, nsig, swg, up);
    @(negedge clk);
    chk({tag, ".upd_drop"}, int'(bus.upd), 0);
  endtask

  initial begin
    rst_n = 1'b1; bus.en = 1'b0; bus.den = 1'b0; bus.din = 8'd0;
    repeat (2) @(negedge clk);
    chk_all("reset", 128, 0, 1, 0, 0);

    @(negedge clk); rst_n = 1'b0; bus.en = 1'b1;   // IDLE -> ACQ
    send(8'd40, 8'd200, 16, 1'b0);
    finish_win("w40_200", 1'b0, 8'd0, 120, 1, 0, 160, 1);

    send(8'd41, 8'd201, 16, 1'b0);
    finish_win("hyst_hold", 1'b0, 8'd0, 120, 1, 0, 160, 0);

    send(8'd50, 8'd210, 16, 1'b0);
    finish_win("w50_210", 1'b0, 8'd0, 130, 1, 0, 160, 1);

    for (int w = 1; w <= 3; w++) begin
      send(8'd100, 8'd100, 16, 1'b0);
      finish_win($sformatf("weak%0d", w), 1'b0, 8'd0, 130, 1, 1, 0, 0);
    end
    send(8'd100, 8'd100, 16, 1'b0);
    finish_win("weak4", 1'b0, 8'd0, 128, 0, 1, 0, 1);

    send(8'd0, 8'd255, 16, 1'b0);
    finish_win("w0_255", 1'b0, 8'd0, 127, 1, 0, 255, 1);

    // sparse den; the UPDATE-cycle sample (din=0) must be dropped
    send(8'd20, 8'd220, 16, 1'b1);
    finish_win("sparse", 1'b1, 8'd0, 120, 1, 0, 200, 1);
    send(8'd100, 8'd164, 16, 1'b0);
    finish_win("after_sparse", 1'b0, 8'd0, 132, 1, 0, 64, 1);

    // en dropped mid-window: partial 10/250 window must vanish
    send(8'd10, 8'd250, 10, 1'b0);
    @(negedge clk); bus.en = 1'b0; bus.den = 1'b1; bus.din = 8'd0;
    @(negedge clk); bus.en = 1'b1; bus.den = 1'b0;
    chk_all("en_drop", 132, 1, 0, 64, 0);
    send(8'd60, 8'd140, 16, 1'b0);
    finish_win("w60_140", 1'b0, 8'd0, 100, 1, 0, 80, 1);

    // reset in the middle of acquisition
    send(8'd40, 8'd200, 16, 1'b0);
    finish_win("pre_rst", 1'b0, 8'd0, 120, 1, 0, 160, 1);
    send(8'd30, 8'd220, 5, 1'b0);
    @(negedge clk); rst_n = 1'b1; bus.den = 1'b0;
    @(negedge clk);
    chk_all("mid_rst", 128, 0, 1, 0, 0);
    rst_n = 1'b0;                                   // en still 1: IDLE -> ACQ
    send(8'd40, 8'd200, 16, 1'b0);
    finish_win("post_rst", 1'b0, 8'd0, 120, 1, 0, 160, 1);

    bus.en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // runaway guard
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
